// File: rtl/timer_cmd_scheduler_pkg.sv
// Shared opcode and FSM-state definitions for the timer command scheduler.
package timer_cmd_scheduler_pkg;

   typedef enum logic [1:0] {
      OP_START       = 2'd0,
      OP_CAPTURE     = 2'd1,
      OP_RST_CAPTURE = 2'd2,
      OP_READ        = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PULSE  = 3'd1,
      ST_GAP    = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/timer_cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request after the last winner.
module timer_cmd_scheduler_rr_arbiter
   import timer_cmd_scheduler_pkg::*;
#(
   parameter  int NB_REQUESTERS = 4,
   localparam int IDX_W         = (NB_REQUESTERS > 1) ? $clog2(NB_REQUESTERS) : 1
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [NB_REQUESTERS-1:0] req,
   input  logic                     en,
   output logic [NB_REQUESTERS-1:0] grant,
   output logic [IDX_W-1:0]         idx
);

   logic [IDX_W-1:0] ptr_q;

   always_comb begin
      int  j;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 1; i <= NB_REQUESTERS; i++) begin
         j = (int'(ptr_q) + i) % NB_REQUESTERS;
         if (en && !found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

   // Pointer only moves on an actual grant so idle cycles keep the rotation.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         ptr_q <= IDX_W'(NB_REQUESTERS - 1);
      else if (|grant)
         ptr_q <= idx;
   end

endmodule

// File: rtl/timer_cmd_scheduler.sv
// Arbitrates timer commands from several requesters, shapes strobe pulses and
// returns counter/captured words over a valid/ready response channel.
//
//   state  | meaning
//   IDLE   | arbitrate, grant one requester, latch op/ch
//   PULSE  | strobe bit [ch] of the op's vector high for PULSE_CYCLES
//   GAP    | all strobes low for PULSE_CYCLES
//   SETTLE | wait CAPTURE_LATENCY, then sample the result word
//   RESP   | hold rsp_valid/data/err until the requester accepts
module timer_cmd_scheduler
   import timer_cmd_scheduler_pkg::*;
#(
   parameter  int TIMER_BITWIDTH  = 32,
   parameter  int NB_CAPTURES     = 10,
   parameter  int NB_REQUESTERS   = 4,
   parameter  int PULSE_CYCLES    = 2,
   parameter  int CAPTURE_LATENCY = 3,
   localparam int CH_W            = (NB_CAPTURES > 1) ? $clog2(NB_CAPTURES) : 1
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic [NB_REQUESTERS-1:0]              req_valid_in,
   input  logic [2*NB_REQUESTERS-1:0]            req_op_in,
   input  logic [CH_W*NB_REQUESTERS-1:0]         req_ch_in,
   output logic [NB_REQUESTERS-1:0]              req_ready_out,
   output logic [NB_REQUESTERS-1:0]              rsp_valid_out,
   input  logic [NB_REQUESTERS-1:0]              rsp_ready_in,
   output logic [TIMER_BITWIDTH-1:0]             rsp_data_out,
   output logic                                  rsp_err_out,
   output logic                                  busy_out,
   output logic [NB_CAPTURES-1:0]                timer_start_out,
   output logic [NB_CAPTURES-1:0]                timer_capture_out,
   output logic [NB_CAPTURES-1:0]                timer_rst_capture_out,
   input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] timer_captured_in,
   input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] timer_counter_in
);

   localparam int IDX_W = (NB_REQUESTERS > 1) ? $clog2(NB_REQUESTERS) : 1;
   localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, CAPTURE_LATENCY) + 1);
   localparam logic [CH_W:0] NC_LIM = (CH_W + 1)'(NB_CAPTURES);

   state_e                     state_q, state_d;
   op_e                        op_q, op_sel, g_op;
   logic [CH_W-1:0]            ch_q, ch_sel, g_ch;
   logic [IDX_W-1:0]           g_q, g_idx;
   logic [NB_REQUESTERS-1:0]   grant;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [TIMER_BITWIDTH-1:0]  data_q, data_d;
   logic                       err_q, err_d;
   logic [NB_CAPTURES-1:0]     start_d, cap_d, rstc_d, ch_oh;
   logic                       arb_en;

   function automatic logic [TIMER_BITWIDTH-1:0] pick(
      input logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] bus,
      input logic [CH_W-1:0]                       ch);
      pick = '0;
      for (int k = 0; k < NB_CAPTURES; k++)
         if (CH_W'(k) == ch) pick = bus[k*TIMER_BITWIDTH +: TIMER_BITWIDTH];
   endfunction

   assign arb_en = (state_q == ST_IDLE) && !rst_in;

   timer_cmd_scheduler_rr_arbiter #(.NB_REQUESTERS(NB_REQUESTERS)) u_arb (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .req    (req_valid_in),
      .en     (arb_en),
      .grant  (grant),
      .idx    (g_idx)
   );

   assign g_op   = op_e'(req_op_in[g_idx*2 +: 2]);
   assign g_ch   = req_ch_in[g_idx*CH_W +: CH_W];
   assign op_sel = (state_q == ST_IDLE) ? g_op : op_q;
   assign ch_sel = (state_q == ST_IDLE) ? g_ch : ch_q;
   assign ch_oh  = NB_CAPTURES'(1) << ch_sel;

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               if ({1'b0, g_ch} >= NC_LIM) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  data_d  = '0;
               end else if (g_op == OP_READ) begin
                  state_d = ST_RESP;
                  err_d   = 1'b0;
                  data_d  = pick(timer_counter_in, g_ch);
               end else begin
                  state_d = ST_PULSE;
                  err_d   = 1'b0;
                  cnt_d   = CNT_W'(PULSE_CYCLES - 1);
               end
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_GAP;
               cnt_d   = CNT_W'(PULSE_CYCLES - 1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(CAPTURE_LATENCY - 1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               data_d  = (op_q == OP_START) ? pick(timer_counter_in, ch_q)
                                            : pick(timer_captured_in, ch_q);
            end
         end
         ST_RESP: begin
            if (rsp_ready_in[g_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Strobes are registered from the next state so they are glitch-free.
      start_d = '0;
      cap_d   = '0;
      rstc_d  = '0;
      if (state_d == ST_PULSE) begin
         case (op_sel)
            OP_START:       start_d = ch_oh;
            OP_CAPTURE:     cap_d   = ch_oh;
            OP_RST_CAPTURE: rstc_d  = ch_oh;
            default:        ;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q               <= ST_IDLE;
         cnt_q                 <= '0;
         op_q                  <= OP_START;
         ch_q                  <= '0;
         g_q                   <= '0;
         data_q                <= '0;
         err_q                 <= 1'b0;
         timer_start_out       <= '0;
         timer_capture_out     <= '0;
         timer_rst_capture_out <= '0;
      end else begin
         state_q               <= state_d;
         cnt_q                 <= cnt_d;
         data_q                <= data_d;
         err_q                 <= err_d;
         timer_start_out       <= start_d;
         timer_capture_out     <= cap_d;
         timer_rst_capture_out <= rstc_d;
         if (|grant) begin
            op_q <= g_op;
            ch_q <= g_ch;
            g_q  <= g_idx;
         end
      end
   end

   assign req_ready_out = grant;
   assign rsp_valid_out = (state_q == ST_RESP) ? (NB_REQUESTERS'(1) << g_q) : '0;
   assign rsp_data_out  = data_q;
   assign rsp_err_out   = err_q;
   assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_timer_cmd_scheduler.sv
// Randomized and directed bench for timer_cmd_scheduler against a transaction-level model.
module tb_timer_cmd_scheduler;

   localparam int TW   = 32;
   localparam int NC   = 10;
   localparam int NR   = 4;
   localparam int P    = 2;
   localparam int L    = 3;
   localparam int CH_W = 4;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic [NR-1:0]        req_valid_in;
   logic [2*NR-1:0]      req_op_in;
   logic [CH_W*NR-1:0]   req_ch_in;
   logic [NR-1:0]        req_ready_out;
   logic [NR-1:0]        rsp_valid_out;
   logic [NR-1:0]        rsp_ready_in;
   logic [TW-1:0]        rsp_data_out;
   logic                 rsp_err_out;
   logic                 busy_out;
   logic [NC-1:0]        timer_start_out;
   logic [NC-1:0]        timer_capture_out;
   logic [NC-1:0]        timer_rst_capture_out;
   logic [TW*NC-1:0]     timer_captured_in;
   logic [TW*NC-1:0]     timer_counter_in;

   timer_cmd_scheduler #(
      .TIMER_BITWIDTH(TW), .NB_CAPTURES(NC), .NB_REQUESTERS(NR),
      .PULSE_CYCLES(P), .CAPTURE_LATENCY(L)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid_in(req_valid_in), .req_op_in(req_op_in), .req_ch_in(req_ch_in),
      .req_ready_out(req_ready_out), .rsp_valid_out(rsp_valid_out),
      .rsp_ready_in(rsp_ready_in), .rsp_data_out(rsp_data_out),
      .rsp_err_out(rsp_err_out), .busy_out(busy_out),
      .timer_start_out(timer_start_out), .timer_capture_out(timer_capture_out),
      .timer_rst_capture_out(timer_rst_capture_out),
      .timer_captured_in(timer_captured_in), .timer_counter_in(timer_counter_in)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [TW-1:0] word(input logic [TW*NC-1:0] bus, input int k);
      return bus[k*TW +: TW];
   endfunction

   function automatic int oh_idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Transaction-level model: one outstanding command, timed from its grant cycle.
   int            cyc = 0;
   bit            m_busy = 1'b0;
   int            m_ptr = NR - 1;
   int            m_g, m_op, m_ch, m_gcyc, m_resp_start;
   bit            m_err;
   logic [TW-1:0] m_data;

   always @(negedge clk_in) begin
      int            gi, j, t, ch;
      logic [NR-1:0] eg, ev;
      logic [NC-1:0] es, ec, er;
      cyc++;
      if (rst_in) begin
         check("rst_ready", req_ready_out, 0);
         check("rst_rsp_valid", rsp_valid_out, 0);
         check("rst_busy", busy_out, 0);
         check("rst_strobes", {timer_start_out, timer_capture_out, timer_rst_capture_out}, 0);
         check("rst_data", {rsp_err_out, rsp_data_out}, 0);
         m_busy = 1'b0;
         m_ptr  = NR - 1;
      end else begin
         gi = -1;
         eg = '0;
         if (!m_busy)
            for (int i = 1; i <= NR; i++) begin
               j = (m_ptr + i) % NR;
               if (gi < 0 && req_valid_in[j]) gi = j;
            end
         if (gi >= 0) eg[gi] = 1'b1;
         es = '0; ec = '0; er = '0;
         t  = cyc - m_gcyc;
         if (m_busy && !m_err && m_op != 3 && t >= 1 && t <= P)
            case (m_op)
               0: es[m_ch] = 1'b1;
               1: ec[m_ch] = 1'b1;
               default: er[m_ch] = 1'b1;
            endcase
         ev = '0;
         if (m_busy && cyc >= m_resp_start) ev[m_g] = 1'b1;
         check("grant", req_ready_out, eg);
         check("busy", busy_out, m_busy);
         check("start_strobe", timer_start_out, es);
         check("capture_strobe", timer_capture_out, ec);
         check("rst_capture_strobe", timer_rst_capture_out, er);
         check("rsp_valid", rsp_valid_out, ev);
         if (ev != '0) begin
            check("rsp_data", rsp_data_out, m_data);
            check("rsp_err", rsp_err_out, m_err);
         end
         if (m_busy && !m_err && m_op != 3 && t == 2*P + L)
            m_data = (m_op == 0) ? word(timer_counter_in, m_ch) : word(timer_captured_in, m_ch);
         if (gi >= 0) begin
            ch     = int'(req_ch_in[CH_W*gi +: CH_W]);
            m_busy = 1'b1;
            m_ptr  = gi;
            m_g    = gi;
            m_gcyc = cyc;
            m_op   = int'(req_op_in[2*gi +: 2]);
            m_ch   = ch;
            m_err  = (ch >= NC);
            if (m_err) begin
               m_data       = '0;
               m_resp_start = cyc + 1;
            end else if (m_op == 3) begin
               m_data       = word(timer_counter_in, ch);
               m_resp_start = cyc + 1;
            end else begin
               m_resp_start = cyc + 2*P + L + 1;
            end
         end else if (m_busy && cyc >= m_resp_start && rsp_ready_in[m_g]) begin
            m_busy = 1'b0;
         end
      end
   end

   task automatic set_req(input int r, input bit v, input int op, input int ch);
      req_valid_in[r]           = v;
      req_op_in[2*r +: 2]       = op[1:0];
      req_ch_in[CH_W*r +: CH_W] = ch[CH_W-1:0];
   endtask

   task automatic fixed_bus();
      for (int k = 0; k < NC; k++) begin
         timer_captured_in[k*TW +: TW] = 32'hC000_0000 + k;
         timer_counter_in[k*TW +: TW]  = 32'h1000_0000 + k;
      end
   endtask

   task automatic wait_idle();
      int n;
      @(posedge clk_in); #1;
      req_valid_in = '0;
      rsp_ready_in = '1;
      n = 0;
      @(negedge clk_in);
      while (busy_out && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 50) check("idle_timeout", busy_out, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants[5];
      int ng, ncap, rsp_t, ix;
      rst_in       = 1'b1;
      req_valid_in = '0;
      req_op_in    = '0;
      req_ch_in    = '0;
      rsp_ready_in = '1;
      fixed_bus();
      for (int r = 0; r < NR; r++) set_req(r, 1'b1, 3, r + 1);

      repeat (3) begin
         @(negedge clk_in);
         check("reset_no_ready", req_ready_out, 0);
      end
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      check("first_grant", req_ready_out, 4'b0001);

      grants[0] = 0;
      ng = 1;
      for (int c = 0; c < 40 && ng < 5; c++) begin
         @(negedge clk_in);
         if (|rsp_valid_out) begin
            ix = oh_idx(rsp_valid_out);
            check("rr_data", rsp_data_out, 32'h1000_0000 + ix + 1);
         end
         if (|req_ready_out) begin
            grants[ng] = oh_idx(req_ready_out);
            ng++;
         end
      end
      check("rr_grant_count", ng, 5);
      for (int i = 0; i < 5; i++) check("rr_order", grants[i], i % 4);

      // CAPTURE on channel 3
      wait_idle();
      @(posedge clk_in); #1;
      set_req(0, 1'b1, 1, 3);
      @(negedge clk_in);
      check("cap_grant", req_ready_out, 4'b0001);
      @(posedge clk_in); #1;
      req_valid_in = '0;
      ncap  = 0;
      rsp_t = -1;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk_in);
         if (timer_capture_out == 10'h008) ncap++;
         check("cap_shape", timer_capture_out, (t <= 2) ? 10'h008 : 10'h000);
         check("cap_other", {timer_start_out, timer_rst_capture_out}, 0);
         if (rsp_valid_out[0] && rsp_t < 0) begin
            rsp_t = t;
            check("cap_data", rsp_data_out, 32'hC000_0003);
         end
      end
      check("cap_high_cycles", ncap, 2);
      check("cap_rsp_latency", rsp_t, 8);

      // Invalid channel 12
      wait_idle();
      @(posedge clk_in); #1;
      set_req(0, 1'b1, 0, 12);
      @(negedge clk_in);
      check("inv_grant", req_ready_out, 4'b0001);
      @(posedge clk_in); #1;
      req_valid_in = '0;
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk_in);
         check("inv_no_strobe", {timer_start_out, timer_capture_out, timer_rst_capture_out}, 0);
         if (t == 1) begin
            check("inv_rsp_valid", rsp_valid_out, 4'b0001);
            check("inv_err", rsp_err_out, 1);
            check("inv_data", rsp_data_out, 0);
         end
      end

      // Backpressure on a READ from requester 2
      wait_idle();
      @(posedge clk_in); #1;
      rsp_ready_in = '0;
      set_req(2, 1'b1, 3, 5);
      @(negedge clk_in);
      check("bp_grant", req_ready_out, 4'b0100);
      @(posedge clk_in); #1;
      set_req(0, 1'b1, 3, 0);
      set_req(1, 1'b1, 3, 1);
      set_req(3, 1'b1, 3, 2);
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk_in);
         check("bp_valid", rsp_valid_out, 4'b0100);
         check("bp_data", rsp_data_out, 32'h1000_0005);
         check("bp_busy", busy_out, 1);
         check("bp_no_grant", req_ready_out, 0);
      end
      @(posedge clk_in); #1;
      rsp_ready_in = '1;
      @(negedge clk_in);
      check("bp_accept_valid", rsp_valid_out, 4'b0100);
      @(negedge clk_in);
      check("bp_next_grant", req_ready_out, 4'b1000);

      // Reset during PULSE
      wait_idle();
      @(posedge clk_in); #1;
      set_req(0, 1'b1, 0, 7);
      @(negedge clk_in);
      check("rp_grant", req_ready_out, 4'b0001);
      @(posedge clk_in); #1;
      req_valid_in = '0;
      @(negedge clk_in);
      check("rp_strobe_high", timer_start_out, 10'h080);
      @(posedge clk_in); #3;
      rst_in = 1'b1;
      #1;
      check("rp_async_strobe", timer_start_out, 0);
      check("rp_async_busy", busy_out, 0);
      #3;
      rst_in = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk_in);
         check("rp_no_stale_rsp", rsp_valid_out, 0);
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk_in); #1;
         rst_in = ($urandom_range(299, 0) == 0);
         for (int r = 0; r < NR; r++)
            set_req(r, ($urandom_range(9, 0) < 7), $urandom_range(3, 0), $urandom_range(11, 0));
         for (int r = 0; r < NR; r++) rsp_ready_in[r] = ($urandom_range(9, 0) < 6);
         for (int k = 0; k < NC; k++) begin
            timer_captured_in[k*TW +: TW] = $urandom();
            timer_counter_in[k*TW +: TW]  = $urandom();
         end
      end
      @(posedge clk_in); #1;
      rst_in       = 1'b0;
      req_valid_in = '0;
      repeat (2) @(negedge clk_in);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
